// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding,
// default bus widths and response-word constants.
package wb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  localparam logic [1:0] WB_RSP_NONE = 2'b00;
  localparam logic [1:0] WB_RSP_ACK  = 2'b01;
  localparam logic [1:0] WB_RSP_ERR  = 2'b10;
  localparam logic [1:0] WB_RSP_TMO  = 2'b11;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin picker: first set request bit above
// the last winner, wrapping modulo NM.
module rr_pick
  import wb_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan last+1 .. last+NM, keep first hit
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      if (!any && req[(int'(last) + i) % NM]) begin
        any = 1'b1;
        idx = IW'((int'(last) + i) % NM);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter with a
// per-transaction watchdog in front of one slave.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NM-1:0]    i_m_cyc,
  input  logic [NM-1:0]    i_m_stb,
  input  logic [NM-1:0]    i_m_we,
  input  logic [NM*AW-1:0] i_m_addr,
  input  logic [NM*DW-1:0] i_m_data,
  output logic [NM-1:0]    o_m_stall,
  output logic [NM-1:0]    o_m_ack,
  output logic [NM-1:0]    o_m_err,
  output logic [DW-1:0]    o_m_data,
  output logic             o_s_cyc,
  output logic             o_s_stb,
  output logic             o_s_we,
  output logic [AW-1:0]    o_s_addr,
  output logic [DW-1:0]    o_s_data,
  input  logic             i_s_stall,
  input  logic             i_s_ack,
  input  logic             i_s_err,
  input  logic [DW-1:0]    i_s_data,
  output logic [NM-1:0]    o_grant,
  output logic             o_timeout
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

  logic [0:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          any;
  logic [TW-1:0] tmr;
  logic          owned;
  logic          rsp;
  logic          wd_fire;

  rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req  (i_m_cyc),
    .last (last),
    .idx  (pick),
    .any  (any)
  );

  assign owned   = (state == ST_OWNED);
  assign rsp     = i_s_ack | i_s_err;
  assign wd_fire = owned && (TIMEOUT != 0)
                && !rsp && (tmr == TMAX);
  assign o_timeout = wd_fire;
  assign o_m_data  = i_s_data;

  // ownership FSM, round-robin history and watchdog
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= LAST_RST;
      tmr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (any) begin
            state <= ST_OWNED;
            owner <= pick;
            last  <= pick;
          end
        end
        ST_OWNED: begin
          if (!i_m_cyc[owner] || wd_fire) begin
            state <= ST_IDLE;
            tmr   <= '0;
          end else if (rsp) begin
            tmr <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // owner's request to slave, slave response to owner
  always_comb begin
    o_grant   = '0;
    o_m_stall = '1;
    o_m_ack   = '0;
    o_m_err   = '0;
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = i_m_we[owner];
    o_s_addr  = i_m_addr[owner*AW +: AW];
    o_s_data  = i_m_data[owner*DW +: DW];
    if (owned) begin
      o_grant[owner]   = 1'b1;
      o_s_cyc          = i_m_cyc[owner];
      o_s_stb          = i_m_stb[owner];
      o_m_stall[owner] = i_s_stall;
      o_m_ack[owner]   = i_s_ack;
      o_m_err[owner]   = i_s_err | wd_fire;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random
// traffic against a per-cycle reference model.
module tb_wb_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_data;
  logic [NM-1:0]    m_stall, m_ack, m_err;
  logic [DW-1:0]    mo_data;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_dout;
  logic             s_stall, s_ack, s_err;
  logic [DW-1:0]    s_din;
  logic [NM-1:0]    grant;
  logic             tmo;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(
    .NM (NM), .AW (AW), .DW (DW), .TIMEOUT (TO)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_m_cyc   (m_cyc),
    .i_m_stb   (m_stb),
    .i_m_we    (m_we),
    .i_m_addr  (m_addr),
    .i_m_data  (m_data),
    .o_m_stall (m_stall),
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_m_data  (mo_data),
    .o_s_cyc   (s_cyc),
    .o_s_stb   (s_stb),
    .o_s_we    (s_we),
    .o_s_addr  (s_addr),
    .o_s_data  (s_dout),
    .i_s_stall (s_stall),
    .i_s_ack   (s_ack),
    .i_s_err   (s_err),
    .i_s_data  (s_din),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // reference model: owner (-1 idle), last winner,
  // cycles owned since the last response
  int own, lst, cnt;
  int beats, acks0, acks1, sent, pend;
  logic acc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NM-1:0] eg, es, ea, ee;
    logic ec, eb, et;
    eg = '0; es = '1; ea = '0; ee = '0;
    ec = 1'b0; eb = 1'b0; et = 1'b0;
    if (own >= 0) begin
      et = (cnt == TO - 1) && !s_ack && !s_err;
      eg[own] = 1'b1;
      ec = m_cyc[own];
      eb = m_stb[own];
      es[own] = s_stall;
      ea[own] = s_ack;
      ee[own] = s_err | et;
      chk("s_we", s_we, m_we[own]);
      chk("s_addr", s_addr, m_addr[own*AW +: AW]);
      chk("s_data", s_dout, m_data[own*DW +: DW]);
    end
    chk("grant", grant, eg);
    chk("s_cyc", s_cyc, ec);
    chk("s_stb", s_stb, eb);
    chk("m_stall", m_stall, es);
    chk("m_ack", m_ack, ea);
    chk("m_err", m_err, ee);
    chk("timeout", tmo, et);
    chk("m_data", mo_data, s_din);
  endtask

  task automatic model_edge();
    logic fire;
    logic found;
    fire = (own >= 0) && (cnt == TO - 1)
        && !s_ack && !s_err;
    if (own < 0) begin
      cnt = 0;
      found = 1'b0;
      for (int i = 1; i <= NM; i++) begin
        if (!found && m_cyc[(lst + i) % NM]) begin
          found = 1'b1;
          own = (lst + i) % NM;
          lst = own;
        end
      end
    end else if (!m_cyc[own] || fire) begin
      own = -1;
      cnt = 0;
    end else if (s_ack || s_err) begin
      cnt = 0;
    end else begin
      cnt++;
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    if (s_cyc && s_stb && !s_stall) beats++;
    acks0 += int'(m_ack[0]);
    acks1 += int'(m_ack[1]);
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    own = -1; lst = NM - 1; cnt = 0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_stall", m_stall, 2'b11);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_tmo", tmo, 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_addr = '0; m_data = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    s_din = 32'hdead_beef;
    beats = 0; acks0 = 0; acks1 = 0;
    do_reset();

    // single master write
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_addr[0 +: AW] = 32'h10;
    m_data[0 +: DW] = 32'h1234_5678;
    tick();
    #1;
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_addr", s_addr, 32'h10);
    chk("t1_grant", grant, 2'b01);
    tick();
    m_stb = 2'b00; s_ack = 1'b1;
    #1;
    chk("t1_ack", m_ack, 2'b01);
    tick();
    s_ack = 1'b0; m_cyc = 2'b00;
    tick();
    #1;
    chk("t1_release", grant, 2'b00);
    tick();

    // contention after reset
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_addr[AW +: AW] = 32'h20;
    tick();
    #1;
    chk("t2_first", grant, 2'b01);
    chk("t2_m1_stall", m_stall[1], 1);
    tick();
    m_stb = 2'b10; s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc = 2'b10;
    tick();
    #1;
    chk("t2_gap", grant, 2'b00);
    tick();
    #1;
    chk("t2_second", grant, 2'b10);
    tick();
    m_stb = 2'b00; s_ack = 1'b1;
    #1;
    chk("t2_m1_ack", m_ack, 2'b10);
    tick();
    s_ack = 1'b0; m_cyc = 2'b00;
    tick();
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    #1;
    chk("t2_rr_back", grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00;
    tick();
    tick();

    // pipelined burst from m1 with slave stall
    beats = 0; acks0 = 0; acks1 = 0;
    sent = 0; pend = 0;
    m_cyc = 2'b10; m_we = 2'b10;
    for (int c = 0; c < 12; c++) begin
      m_stb = (sent < 4) ? 2'b10 : 2'b00;
      m_addr[AW +: AW] = 32'h100 + 32'(sent);
      s_stall = (c == 1 || c == 2);
      s_ack = (pend > 0);
      #1;
      acc = m_stb[1] && !m_stall[1];
      tick();
      if (s_ack) pend--;
      if (acc) begin
        sent++;
        pend++;
      end
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    s_ack = 1'b0; s_stall = 1'b0;
    chk("t3_beats", beats, 4);
    chk("t3_m1_acks", acks1, 4);
    chk("t3_m0_acks", acks0, 0);
    tick();
    tick();

    // watchdog with another master pending
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    for (int i = 1; i < TO; i++) tick();
    #1;
    chk("t4_tmo", tmo, 1);
    chk("t4_err", m_err, 2'b01);
    tick();
    #1;
    chk("t4_s_cyc", s_cyc, 0);
    chk("t4_idle", grant, 2'b00);
    tick();
    #1;
    chk("t4_next", grant, 2'b10);
    tick();
    m_cyc = 2'b00; m_stb = 2'b00;
    tick();
    tick();

    // ack on the expiry cycle
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    for (int i = 1; i < TO; i++) tick();
    s_ack = 1'b1;
    #1;
    chk("t5_tmo", tmo, 0);
    chk("t5_err", m_err, 2'b00);
    chk("t5_ack", m_ack, 2'b01);
    tick();
    s_ack = 1'b0;
    #1;
    chk("t5_kept", grant, 2'b01);
    tick();
    m_cyc = 2'b00; m_stb = 2'b00;
    tick();
    tick();

    // reset during a stalled transaction
    m_cyc = 2'b11; m_stb = 2'b11; s_stall = 1'b1;
    tick();
    #1;
    chk("t6_owned", grant, 2'b10);
    chk("t6_stb", s_stb, 1);
    do_reset();
    tick();
    #1;
    chk("t6_prio", grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00; s_stall = 1'b0;
    tick();
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) m_cyc[0] = ~m_cyc[0];
      if ($urandom_range(7) == 0) m_cyc[1] = ~m_cyc[1];
      m_stb = m_cyc & 2'($urandom);
      m_we = 2'($urandom);
      m_addr = {$urandom, $urandom};
      m_data = {$urandom, $urandom};
      s_din = $urandom;
      s_stall = ($urandom_range(3) == 0);
      s_ack = ($urandom_range(5) == 0);
      s_err = !s_ack && ($urandom_range(19) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
